// File: rtl/uart_pkg.sv
// Shared UART definitions: frame format constants and the receiver state encoding.
package uart_pkg;
  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset value selectable.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic bclk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge bclk) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit validation, centre sampling of data/stop bits,
// and a receiver buffer register with ready/read handshake plus framing/overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                 bclk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 framing_err,
  output logic                 overrun_err
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF     = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_t state, state_nxt;
  logic rx_s;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_BITS-1:0] rsr;
  logic cnt_clr, mid_start, bit_tick, stop_tick;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .bclk  (bclk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  always_ff @(posedge bclk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (rx_s == START_BIT) state_nxt = START;
      START:     if (cnt == HALF) state_nxt = (rx_s == START_BIT) ? DATA : IDLE;
      DATA:      if (cnt == LAST && bit_idx == BIT_LAST) state_nxt = STOP;
      STOP:      if (cnt == LAST) state_nxt = (rx_s == STOP_BIT) ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s == STOP_BIT) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mid_start = (state == START) && (cnt == HALF);
    bit_tick  = (state == DATA)  && (cnt == LAST);
    stop_tick = (state == STOP)  && (cnt == LAST);
    // Holding the counter clear in IDLE gives START a zeroed count on entry.
    cnt_clr   = (state == IDLE) || mid_start || bit_tick || stop_tick;
    rx_busy   = (state != IDLE);
  end

  always_ff @(posedge bclk) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      rsr     <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (mid_start) bit_idx <= '0;
      else if (bit_tick) bit_idx <= bit_idx + 1'b1;
      if (bit_tick) rsr <= {rx_s, rsr[DATA_BITS-1:1]};
    end
  end

  // A store in the same cycle as rd takes priority; the read is absorbed by the new byte.
  always_ff @(posedge bclk) begin
    if (!reset) begin
      d_out       <= '0;
      rx_ready    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else if (stop_tick) begin
      d_out       <= rsr;
      rx_ready    <= 1'b1;
      framing_err <= ~rx_s;
      if (rx_ready && !rd) overrun_err <= 1'b1;
      else if (rd)         overrun_err <= 1'b0;
    end else if (rd && rx_ready) begin
      rx_ready    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end
  end
endmodule
